// File: rtl/uart_rx_if.sv
// Signal bundle of the UART receiver: serial line in, recovered byte and per-frame strobes out.
interface uart_rx_if;
    logic       rx;
    logic [7:0] dout;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    // master drives the line and consumes bytes; slave is the receiver itself
    modport master (output rx, input dout, rx_valid, frame_err, busy);
    modport slave  (input rx, output dout, rx_valid, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver oversampled from clk; one-clk byte strobe or framing-error strobe per frame.
// Build macro UART_RX_MAJORITY_EN selects a 2-of-3 vote around each bit centre.
module uart_rx #(
    parameter int clk_freq = 32'd1000000,
    parameter int baud     = 32'd9600,
    parameter int OVS      = 32'd16
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_if.slave  bus
);
    localparam int DIV = clk_freq / (baud * OVS);
    localparam int PW  = (DIV > 32'sd1) ? $clog2(DIV) : 32'sd1;
    localparam int TW  = $clog2(OVS);

    if (DIV < 32'sd1) begin : g_div_check
        $error("uart_rx: clk_freq/(baud*OVS) must be at least 1");
    end
    if ((OVS < 32'sd4) || ((OVS % 32'sd2) != 32'sd0)) begin : g_ovs_check
        $error("uart_rx: OVS must be even and at least 4");
    end

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;

`ifdef UART_RX_MAJORITY_EN
    // the vote needs the sample one tick past centre, so the start decision moves one tick later
    localparam logic [TW-1:0] START_DEC = TW'(OVS / 32'sd2);
`else
    localparam logic [TW-1:0] START_DEC = TW'(OVS / 32'sd2 - 32'sd1);
`endif
    localparam logic [TW-1:0] BIT_DEC = TW'(OVS - 32'sd1);
    localparam logic [PW-1:0] PRE_TOP = PW'(DIV - 32'sd1);

    logic          sync1_r, sync2_r, rx_s;
    logic [2:0]    state_r, state_n;
    logic [PW-1:0] presc_r, presc_n;
    logic [TW-1:0] tick_cnt_r, tick_n;
    logic [2:0]    bit_idx_r, bit_n;
    logic [7:0]    shift_r, shift_n;
    logic [7:0]    dout_r, dout_n;
    logic          rx_valid_r, valid_n;
    logic          frame_err_r, ferr_n;
    logic          busy_r;
    logic          in_frame_s, tick_s, bit_val_s;

    // two-flop synchronizer for the asynchronous serial line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= bus.rx;
            sync2_r <= sync1_r;
        end
    end

    assign rx_s       = sync2_r;
    assign in_frame_s = (state_r == ST_START) || (state_r == ST_DATA) || (state_r == ST_STOP);
    assign tick_s     = in_frame_s && (presc_r == PRE_TOP);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] samp_r;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // history of the two previous tick samples; the current rx_s is the third vote
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_r <= 2'b11;
        end else if (tick_s) begin
            samp_r <= {samp_r[0], rx_s};
        end else begin
            samp_r <= samp_r;
        end
    end

    assign bit_val_s = maj3(samp_r[1], samp_r[0], rx_s);
`else
    assign bit_val_s = rx_s;
`endif

    // frame sequencing: next-state, counters, shift register and strobes
    always_comb begin
        state_n = state_r;
        presc_n = presc_r;
        tick_n  = tick_cnt_r;
        bit_n   = bit_idx_r;
        shift_n = shift_r;
        dout_n  = dout_r;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        if (in_frame_s) begin
            presc_n = tick_s ? '0 : presc_r + PW'(1);
        end else begin
            presc_n = '0;
        end
        case (state_r)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_n = ST_START;
                    tick_n  = '0;
                    bit_n   = 3'd0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s && (tick_cnt_r == START_DEC)) begin
                    tick_n  = '0;
                    bit_n   = 3'd0;
                    state_n = bit_val_s ? ST_IDLE : ST_DATA;
                end else if (tick_s) begin
                    tick_n = tick_cnt_r + TW'(1);
                end else begin
                    tick_n = tick_cnt_r;
                end
            end
            ST_DATA: begin
                if (tick_s && (tick_cnt_r == BIT_DEC)) begin
                    tick_n  = '0;
                    shift_n = {bit_val_s, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        state_n = ST_STOP;
                        bit_n   = 3'd0;
                    end else begin
                        bit_n = bit_idx_r + 3'd1;
                    end
                end else if (tick_s) begin
                    tick_n = tick_cnt_r + TW'(1);
                end else begin
                    tick_n = tick_cnt_r;
                end
            end
            ST_STOP: begin
                if (tick_s && (tick_cnt_r == BIT_DEC)) begin
                    tick_n = '0;
                    if (bit_val_s) begin
                        dout_n  = shift_r;
                        valid_n = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = ST_WAIT;
                    end
                end else if (tick_s) begin
                    tick_n = tick_cnt_r + TW'(1);
                end else begin
                    tick_n = tick_cnt_r;
                end
            end
            ST_WAIT: begin
                // a break or stuck-low line must rise before a new start can be armed
                if (rx_s) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_WAIT;
                end
            end
            default: begin
                state_n = ST_IDLE;
                tick_n  = '0;
                bit_n   = 3'd0;
            end
        endcase
    end

    // state, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            presc_r     <= '0;
            tick_cnt_r  <= '0;
            bit_idx_r   <= 3'd0;
            shift_r     <= 8'h00;
            dout_r      <= 8'h00;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            presc_r     <= presc_n;
            tick_cnt_r  <= tick_n;
            bit_idx_r   <= bit_n;
            shift_r     <= shift_n;
            dout_r      <= dout_n;
            rx_valid_r  <= valid_n;
            frame_err_r <= ferr_n;
            busy_r      <= (state_n != ST_IDLE);
        end
    end

    assign bus.dout      = dout_r;
    assign bus.rx_valid  = rx_valid_r;
    assign bus.frame_err = frame_err_r;
    assign bus.busy      = busy_r;
endmodule
